// File: rtl/pipe_stage_chain.sv
// Elastic pipeline register chain: DEPTH slots with per-slot valid bits, a valid/ready
// handshake, backpressure stall, bubble collapsing and a synchronous flush.
module pipe_stage_chain #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count
);

    logic [DEPTH-1:0]  v;
    logic [DATA_W-1:0] d     [DEPTH];
    logic [DEPTH-1:0]  rdy;
    logic [DEPTH-1:0]  src_v;
    logic [DATA_W-1:0] src_d [DEPTH];
    logic              acc;
    logic              del;

    // A slot can load when it is empty or when the slot ahead of it moves on;
    // the running term walks from out_ready back towards slot 0.
    always_comb begin
        logic r;
        rdy = '0;
        r   = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            r      = ~v[i] | r;
            rdy[i] = r;
        end
    end

    always_comb begin
        src_v    = '0;
        src_d    = '{default: '0};
        src_v[0] = in_valid;
        src_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_v[i] = v[i-1];
            src_d[i] = d[i-1];
        end
    end

    assign in_ready  = rdy[0] & ~clr;
    assign out_valid = v[DEPTH-1] & ~clr;
    assign out_data  = d[DEPTH-1];
    assign acc       = in_valid & in_ready;
    assign del       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v     <= '0;
            d     <= '{default: '0};
            count <= '0;
        end else if (clr) begin
            v     <= '0;
            d     <= '{default: '0};
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v[i] <= src_v[i];
                    // Payload only moves with a real beat, so stale data sits still.
                    if (src_v[i]) begin
                        d[i] <= src_d[i];
                    end
                end
            end
            count <= count + CNT_W'(acc) - CNT_W'(del);
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: a DEPTH=3 chain for the main scenarios and a
// DEPTH=1 chain for the single-stage case.
module tb_pipe_stage_chain;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [1:0] count;

    logic       b_in_valid;
    logic [7:0] b_in_data;
    logic       b_in_ready;
    logic       b_out_valid;
    logic [7:0] b_out_data;
    logic       b_out_ready;
    logic [0:0] b_count;

    int checks;
    int failures;

    pipe_stage_chain #(.DATA_W(8), .DEPTH(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    pipe_stage_chain #(.DATA_W(8), .DEPTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_ready (b_out_ready),
        .count     (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        clr         = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        out_ready   = 1'b0;
        b_in_valid  = 1'b0;
        b_in_data   = 8'h00;
        b_out_ready = 1'b0;

        tick();
        tick();
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_count", count, 2'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1'b1);

        // Async reset with two beats in flight
        in_valid = 1'b1; in_data = 8'hB1;
        tick();
        in_data = 8'hB2;
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        chk("pre_rst_out_valid", out_valid, 1'b1);
        chk("pre_rst_out_data", out_data, 8'hB1);
        chk("pre_rst_count", count, 2'd2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_out_data", out_data, 8'h00);
        chk("async_rst_count", count, 2'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel2_in_ready", in_ready, 1'b1);

        // Latency: three consecutive beats with out_ready high
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'hA1;
        #1;
        chk("lat_in_ready", in_ready, 1'b1);
        tick();
        in_data = 8'hA2;
        #1;
        chk("lat_c1_out_valid", out_valid, 1'b0);
        tick();
        in_data = 8'hA3;
        #1;
        chk("lat_c2_out_valid", out_valid, 1'b0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("lat_c3_out_valid", out_valid, 1'b1);
        chk("lat_c3_out_data", out_data, 8'hA1);
        chk("lat_c3_count", count, 2'd3);
        tick();
        #1;
        chk("lat_c4_out_data", out_data, 8'hA2);
        tick();
        #1;
        chk("lat_c5_out_data", out_data, 8'hA3);
        tick();
        #1;
        chk("lat_drained_out_valid", out_valid, 1'b0);
        chk("lat_drained_count", count, 2'd0);

        // Backpressure: fourth beat refused until the sink wakes
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h11;
        tick();
        in_data = 8'h12;
        tick();
        in_data = 8'h13;
        tick();
        in_data = 8'h14;
        #1;
        chk("bp_in_ready_full", in_ready, 1'b0);
        chk("bp_count_full", count, 2'd3);
        tick();
        #1;
        chk("bp_still_full", in_ready, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_drain", in_ready, 1'b1);
        chk("bp_out_11", out_data, 8'h11);
        tick();
        in_valid = 1'b0;
        #1;
        chk("bp_out_12", out_data, 8'h12);
        chk("bp_count_acc_del", count, 2'd3);
        tick();
        #1;
        chk("bp_out_13", out_data, 8'h13);
        tick();
        #1;
        chk("bp_out_14", out_data, 8'h14);
        chk("bp_out_14_valid", out_valid, 1'b1);
        tick();
        #1;
        chk("bp_drained_valid", out_valid, 1'b0);
        chk("bp_drained_count", count, 2'd0);

        // Bubble collapse behind a stalled head
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h55;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #1;
        chk("bub_head_valid", out_valid, 1'b1);
        chk("bub_head_data", out_data, 8'h55);
        chk("bub_count1", count, 2'd1);
        in_valid = 1'b1; in_data = 8'h66;
        #1;
        chk("bub_in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("bub_count2", count, 2'd2);
        tick();
        tick();
        out_ready = 1'b1;
        #1;
        chk("bub_out_55", out_data, 8'h55);
        tick();
        #1;
        chk("bub_out_66_valid", out_valid, 1'b1);
        chk("bub_out_66", out_data, 8'h66);
        tick();
        #1;
        chk("bub_drained", out_valid, 1'b0);

        // Flush with a beat offered in the same cycle
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h21;
        tick();
        in_data = 8'h22;
        tick();
        #1;
        chk("fl_count_pre", count, 2'd2);
        clr = 1'b1; in_data = 8'h77; out_ready = 1'b1;
        #1;
        chk("fl_in_ready", in_ready, 1'b0);
        chk("fl_out_valid", out_valid, 1'b0);
        tick();
        clr = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_count_post", count, 2'd0);
        chk("fl_out_valid_post", out_valid, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            chk("fl_no_77", out_valid, 1'b0);
        end

        // Full streaming: accept and deliver every cycle
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 8'h30 + 8'(k);
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data = 8'h33 + 8'(k);
            #1;
            chk("st_in_ready", in_ready, 1'b1);
            chk("st_out_valid", out_valid, 1'b1);
            chk("st_out_data", out_data, 8'h30 + 8'(k));
            chk("st_count", count, 2'd3);
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("st_tail_data", out_data, 8'h3A + 8'(k));
            tick();
        end
        #1;
        chk("st_empty_count", count, 2'd0);

        // Single-stage chain
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_data = 8'hC1;
        #1;
        chk("d1_in_ready_empty", b_in_ready, 1'b1);
        tick();
        b_in_data = 8'hC2;
        #1;
        chk("d1_out_valid", b_out_valid, 1'b1);
        chk("d1_out_c1", b_out_data, 8'hC1);
        chk("d1_count_full", b_count, 1'b1);
        chk("d1_in_ready_full", b_in_ready, 1'b0);
        b_out_ready = 1'b1;
        #1;
        chk("d1_in_ready_drain", b_in_ready, 1'b1);
        tick();
        b_in_valid = 1'b0;
        #1;
        chk("d1_out_c2", b_out_data, 8'hC2);
        chk("d1_count_swap", b_count, 1'b1);
        tick();
        #1;
        chk("d1_empty_valid", b_out_valid, 1'b0);
        chk("d1_empty_count", b_count, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
